// File: rtl/mem_pair_adder_pkg.sv
// Shared types for the memory pair engine: FSM state encoding
// and the add/subtract operation select constants.
package mem_pair_adder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDA,
    S_RDB,
    S_CAPB,
    S_WR,
    S_DONE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mem_pair_alu.sv
// Pair ALU: result = a+b or a-b, DATA_W+1 bits (MSB is carry/borrow).
// Ports: op_a, op_b, op_sub in; result out. Purely combinational.
module mem_pair_alu
  import mem_pair_adder_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              op_sub,
  output logic [DATA_W:0]   result
);

  logic [DATA_W:0] a_x;
  logic [DATA_W:0] b_x;

  assign a_x = {1'b0, op_a};
  assign b_x = {1'b0, op_b};

  // The subtract wraps mod 2^(DATA_W+1) so the MSB reads as borrow.
  always_comb begin
    result = a_x + b_x;
    unique case (op_sub)
      OP_ADD: result = a_x + b_x;
      OP_SUB: result = a_x - b_x;
    endcase
  end

endmodule

// File: rtl/mem_pair_adder.sv
// Memory-to-memory pair engine: reads operand pairs from a source BRAM, adds
// or subtracts them, writes DATA_W+1-bit results to a destination BRAM.
// Ports: clk, reset (async active-low), start/op_sub/src_base/dst_base/len
// job request, busy/done status, src_* and dst_* BRAM ports.
// Optional macro MEM_PAIR_ADDER_STATS_EN adds the carry_cnt output.
module mem_pair_adder
  import mem_pair_adder_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op_sub,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              src_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_rdata,
  output logic              dst_en,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W:0]   dst_wdata
`ifdef MEM_PAIR_ADDER_STATS_EN
  ,
  output logic [ADDR_W-1:0] carry_cnt
`endif
);

  state_t state;
  state_t state_nx;

  logic              op_sub_q;
  logic [ADDR_W-1:0] sptr;
  logic [ADDR_W-1:0] dptr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] len_q;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W:0]   result;
  logic              accept;
  logic              last;

  assign accept = (state == S_IDLE) && start;
  assign last   = (cnt == len_q - ADDR_W'(1));

  mem_pair_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op_a  (op_a),
    .op_b  (op_b),
    .op_sub(op_sub_q),
    .result(result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    src_en    = 1'b0;
    src_addr  = '0;
    dst_en    = 1'b0;
    dst_we    = 1'b0;
    dst_addr  = '0;
    dst_wdata = '0;
    case (state)
      S_IDLE: begin
        if (start)
          state_nx = (len == '0) ? S_DONE : S_RDA;
      end
      S_RDA: begin
        src_en   = 1'b1;
        src_addr = sptr;
        state_nx = S_RDB;
      end
      S_RDB: begin
        src_en   = 1'b1;
        src_addr = sptr + ADDR_W'(1);
        state_nx = S_CAPB;
      end
      S_CAPB: begin
        state_nx = S_WR;
      end
      S_WR: begin
        dst_en    = 1'b1;
        dst_we    = 1'b1;
        dst_addr  = dptr;
        dst_wdata = result;
        state_nx  = last ? S_DONE : S_RDA;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // BRAM data lags the address by one cycle, so operand A is
  // captured in S_RDB and operand B in S_CAPB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_sub_q <= 1'b0;
      sptr     <= '0;
      dptr     <= '0;
      cnt      <= '0;
      len_q    <= '0;
      op_a     <= '0;
      op_b     <= '0;
    end else begin
      if (accept) begin
        op_sub_q <= op_sub;
        sptr     <= src_base;
        dptr     <= dst_base;
        len_q    <= len;
        cnt      <= '0;
      end
      if (state == S_RDB)
        op_a <= src_rdata;
      if (state == S_CAPB)
        op_b <= src_rdata;
      if (state == S_WR) begin
        sptr <= sptr + ADDR_W'(2);
        dptr <= dptr + ADDR_W'(1);
        cnt  <= cnt + ADDR_W'(1);
      end
    end
  end

`ifdef MEM_PAIR_ADDER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      carry_cnt <= '0;
    else if (accept)
      carry_cnt <= '0;
    else if (state == S_WR && result[DATA_W] && carry_cnt != '1)
      carry_cnt <= carry_cnt + ADDR_W'(1);
  end
`endif

endmodule

// File: tb/tb_mem_pair_adder.sv
// Self-checking bench for mem_pair_adder: BRAM models, a job-level
// reference model (expected read/write queues) and directed jobs.
module tb_mem_pair_adder;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          op_sub = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [AW-1:0] len = '0;
  logic          busy, done, src_en, dst_en, dst_we;
  logic [AW-1:0] src_addr, dst_addr;
  logic [DW-1:0] src_rdata;
  logic [DW:0]   dst_wdata;
`ifdef MEM_PAIR_ADDER_STATS_EN
  logic [AW-1:0] carry_cnt;
`endif

  logic [DW-1:0] src_mem [8];
  logic [DW:0]   dst_mem [8];

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0]    rd_q [$];
  logic [AW+DW:0]   wr_q [$];

  always #5 clk = ~clk;

  mem_pair_adder #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op_sub   (op_sub),
    .src_base (src_base),
    .dst_base (dst_base),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .src_en   (src_en),
    .src_addr (src_addr),
    .src_rdata(src_rdata),
    .dst_en   (dst_en),
    .dst_we   (dst_we),
    .dst_addr (dst_addr),
    .dst_wdata(dst_wdata)
`ifdef MEM_PAIR_ADDER_STATS_EN
    ,
    .carry_cnt(carry_cnt)
`endif
  );

  always @(posedge clk) begin
    if (src_en) src_rdata <= src_mem[src_addr];
    if (dst_en && dst_we) dst_mem[dst_addr] <= dst_wdata;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Compare process: every read and write strobe must match the
  // next entry the model expects, in order.
  always @(negedge clk) begin
    if (reset) begin
      if (src_en) begin
        if (rd_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_read: got addr %0d want none", src_addr);
        end else begin
          check("rd_addr", 32'(src_addr), 32'(rd_q.pop_front()));
        end
      end
      if (dst_we || dst_en) begin
        if (wr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %0d data %0d want none",
                   dst_addr, dst_wdata);
        end else begin
          check("wr_en_addr_data",
                32'({dst_en, dst_we, dst_addr, dst_wdata}),
                32'({2'b11, wr_q.pop_front()}));
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_strobes"}, 32'({src_en, dst_en, dst_we}), 32'd0);
    check({tag, "_addrs"}, 32'({src_addr, dst_addr}), 32'd0);
    check({tag, "_wdata"}, 32'(dst_wdata), 32'd0);
  endtask

  task automatic run_job(input logic sub, input logic [AW-1:0] sb,
                         input logic [AW-1:0] db, input logic [AW-1:0] l,
                         input bit poke);
    int lat;
    int carries;
    carries = 0;
    for (int i = 0; i < int'(l); i++) begin
      logic [AW-1:0] ra, rb, wa;
      logic [DW:0]   r;
      ra = sb + AW'(2 * i);
      rb = ra + AW'(1);
      wa = db + AW'(i);
      rd_q.push_back(ra);
      rd_q.push_back(rb);
      if (sub) r = {1'b0, src_mem[ra]} - {1'b0, src_mem[rb]};
      else     r = {1'b0, src_mem[ra]} + {1'b0, src_mem[rb]};
      if (r[DW]) carries++;
      wr_q.push_back({wa, r});
    end
    @(negedge clk);
    start = 1'b1;
    op_sub = sub;
    src_base = sb;
    dst_base = db;
    len = l;
    @(negedge clk);
    start = 1'b0;
    op_sub = ~sub;
    src_base = ~sb;
    dst_base = ~db;
    len = ~l;
    lat = 2;
    while (!done && lat < 100) begin
      start = (poke && lat == 4);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("latency", 32'(lat), 32'(4 * int'(l) + 2));
    check("busy_at_done", 32'(busy), 32'd1);
`ifdef MEM_PAIR_ADDER_STATS_EN
    check("carry_cnt", 32'(carry_cnt), 32'((carries > 7) ? 7 : carries));
`endif
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("reads_left", 32'(rd_q.size()), 32'd0);
    check("writes_left", 32'(wr_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    for (int i = 0; i < 8; i++) begin
      src_mem[i] = '0;
      dst_mem[i] = '0;
    end
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Add with carry into the MSB
    src_mem[0] = 8'd3;
    src_mem[1] = 8'd5;
    src_mem[2] = 8'd200;
    src_mem[3] = 8'd100;
    run_job(1'b0, 3'd0, 3'd0, 3'd2, 1'b0);
    check("add_dst0", 32'(dst_mem[0]), 32'd8);
    check("add_dst1", 32'(dst_mem[1]), 32'd300);

    // Subtract with borrow
    src_mem[0] = 8'd5;
    src_mem[1] = 8'd7;
    run_job(1'b1, 3'd0, 3'd0, 3'd1, 1'b0);
    check("sub_dst0", 32'(dst_mem[0]), 32'h1FE);
`ifdef MEM_PAIR_ADDER_STATS_EN
    check("sub_carry_cnt", 32'(carry_cnt), 32'd1);
`endif

    // Pointer wrap through address 0
    src_mem[6] = 8'd10;
    src_mem[7] = 8'd20;
    src_mem[0] = 8'd30;
    src_mem[1] = 8'd40;
    run_job(1'b0, 3'd6, 3'd7, 3'd2, 1'b0);
    check("wrap_dst7", 32'(dst_mem[7]), 32'd30);
    check("wrap_dst0", 32'(dst_mem[0]), 32'd70);

    // Zero-length job
    run_job(1'b0, 3'd2, 3'd2, 3'd0, 1'b0);
    check("len0_dst2", 32'(dst_mem[2]), 32'd0);

    // Start pulsed while busy must be ignored
    src_mem[2] = 8'd9;
    src_mem[3] = 8'd4;
    run_job(1'b1, 3'd2, 3'd3, 3'd1, 1'b1);
    check("poke_dst3", 32'(dst_mem[3]), 32'd5);
    repeat (10) @(negedge clk);
    check("poke_no_restart", 32'(busy), 32'd0);

    // Reset mid-job: no write, no done
    src_mem[4] = 8'd1;
    src_mem[5] = 8'd1;
    rd_q.push_back(3'd4);
    rd_q.push_back(3'd5);
    start = 1'b1;
    op_sub = 1'b0;
    src_base = 3'd4;
    dst_base = 3'd0;
    len = 3'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    rd_q.delete();
    wr_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("mid_reset_no_done", 32'(dn), 32'd0);
    check_idle_outputs("after_mid_reset");
    check("mid_reset_dst0", 32'(dst_mem[0]), 32'd70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
